// File: rtl/gf_2m_log.sv
// gf_2m_log: sequential discrete logarithm over GF(2^m).
//   Finds k with alpha^k == a (alpha = x) by stepping acc = alpha^cnt one
//   field multiply per clock and comparing against the latched element.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   start - request, sampled only in IDLE
//   a     - element to take the log of (latched on accepted start)
//   p     - field polynomial, x^m term implied (latched on accepted start)
//   busy  - high while searching
//   done  - one-cycle result-valid pulse
//   k     - exponent result, held until the next accepted start
//   err   - a==0 or no match found, held with k
// Build option:
//   GF_LOG_ORDER_CHECK_EN - abort a miss early once acc returns to 1,
//   i.e. when alpha has order below 2^m-1 under a non-primitive p.
module gf_2m_log #(
  parameter int unsigned m = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [m-1:0] a,
  input  logic [m-1:0] p,
  output logic         busy,
  output logic         done,
  output logic [m-1:0] k,
  output logic         err
);

  localparam logic [m-1:0] ONE     = {{(m-1){1'b0}}, 1'b1};
  localparam logic [m-1:0] ALPHA   = {{(m-2){1'b0}}, 2'b10};
  // 2^m-2: all ones except the LSB
  localparam logic [m-1:0] CNT_MAX = {{(m-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t       state_q, state_d;
  logic [m-1:0] acc;
  logic [m-1:0] a_r;
  logic [m-1:0] p_r;
  logic [m-1:0] cnt;
  logic         hit;
  logic         stop;

  // Shift-and-add multiply modulo x^m + poly, MSB of y first.
  function automatic logic [m-1:0] gf_2m_mult(input logic [m-1:0] x,
                                               input logic [m-1:0] y,
                                               input logic [m-1:0] poly);
    logic [m-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < m; i++) begin
      r = {r[m-2:0], 1'b0} ^ (r[m-1] ? poly : '0);
      if (y[m-1-i]) r = r ^ x;
    end
    return r;
  endfunction

  assign hit = (acc == a_r);

`ifdef GF_LOG_ORDER_CHECK_EN
  // acc back at 1 after the first step means the cyclic subgroup is exhausted
  assign stop = (cnt == CNT_MAX) || ((acc == ONE) && (cnt != '0));
`else
  assign stop = (cnt == CNT_MAX);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (a == '0) ? DONE : SEARCH;
      end
      SEARCH: begin
        busy = 1'b1;
        if (hit || stop) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      a_r <= '0;
      p_r <= '0;
      cnt <= '0;
      k   <= '0;
      err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_r <= a;
            p_r <= p;
            acc <= ONE;
            cnt <= '0;
            err <= (a == '0);
            if (a == '0) k <= '0;
          end
        end
        SEARCH: begin
          if (hit) begin
            k   <= cnt;
            err <= 1'b0;
          end else if (stop) begin
            k   <= '0;
            err <= 1'b1;
          end else begin
            acc <= gf_2m_mult(acc, ALPHA, p_r);
            cnt <= cnt + ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_2m_log.sv
module tb_gf_2m_log;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] p;
  logic       busy;
  logic       done;
  logic [3:0] k;
  logic       err;

  int checks   = 0;
  int failures = 0;

`ifdef GF_LOG_ORDER_CHECK_EN
  localparam bit ORD_CHK = 1'b1;
`else
  localparam bit ORD_CHK = 1'b0;
`endif

  gf_2m_log #(.m(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .p    (p),
    .busy (busy),
    .done (done),
    .k    (k),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: enumerate powers of x as integers reduced by x^4 + p,
  // take the first hit; otherwise derive the miss latency from alpha's order.
  function automatic void ref_log(input int av, input int pv,
                                  output int ek, output int eerr, output int ecyc);
    int pw;
    int ord;
    if (av == 0) begin
      ek = 0; eerr = 1; ecyc = 1;
      return;
    end
    ek = -1;
    pw = 1;
    for (int i = 0; i < 15; i++) begin
      if (pw == av && ek < 0) ek = i;
      pw = pw * 2;
      if (pw >= 16) pw = pw ^ (16 | pv);
    end
    ord = 15;
    pw = 1;
    for (int i = 1; i < 15; i++) begin
      pw = pw * 2;
      if (pw >= 16) pw = pw ^ (16 | pv);
      if (pw == 1 && ord == 15) ord = i;
    end
    if (ek >= 0) begin
      eerr = 0; ecyc = ek + 2;
    end else begin
      ek = 0; eerr = 1;
      ecyc = (ORD_CHK && ord < 15) ? ord + 2 : 16;
    end
  endfunction

  // Start in cycle 0, optionally re-pulse start in cycles re1/re2,
  // scramble a/p after acceptance, and watch until two cycles past done.
  task automatic do_op(input int ai, input int pi, input int re1, input int re2,
                       input string name);
    int ek, eerr, ecyc, dcyc, bcnt, dcnt, gk, gerr;
    ref_log(ai, pi, ek, eerr, ecyc);
    @(negedge clk);
    start = 1'b1; a = 4'(ai); p = 4'(pi);
    dcyc = -1; bcnt = 0; dcnt = 0; gk = -1; gerr = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == re1) || (c == re2);
      a = 4'($urandom);
      p = 4'($urandom);
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (dcyc < 0) begin
          dcyc = c; gk = int'(k); gerr = int'(err);
        end
      end
      if (dcyc >= 0 && c >= dcyc + 2) break;
    end
    start = 1'b0;
    check({name, ".done_cyc"}, dcyc, ecyc);
    check({name, ".k"}, gk, ek);
    check({name, ".err"}, gerr, eerr);
    check({name, ".busy_cnt"}, bcnt, ecyc - 1);
    check({name, ".done_cnt"}, dcnt, 1);
    check({name, ".k_hold"}, int'(k), ek);
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; a = '0; p = 4'b0011;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.k", int'(k), 0);
    check("rst.err", int'(err), 0);

    do_op(4'h1, 4'b0011, -1, -1, "a1");
    do_op(4'h9, 4'b0011, -1, -1, "a9");
    do_op(4'h3, 4'b0011, -1, -1, "a3");
    do_op(4'hB, 4'b0011, -1, -1, "aB");
    do_op(4'hF, 4'b0011, -1, -1, "aF");
    do_op(4'h0, 4'b0011, -1, -1, "a0");
    do_op(4'h3, 4'b1111, -1, -1, "np3");
    do_op(4'hF, 4'b1111, -1, -1, "npF");
    do_op(4'hD, 4'b0011, 3, 15, "ign");

    // Reset mid-search: no done pulse, outputs cleared
    @(negedge clk);
    start = 1'b1; a = 4'h9; p = 4'b0011;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.busy", int'(busy), 0);
    check("rstmid.k", int'(k), 0);
    check("rstmid.err", int'(err), 0);
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("rstmid.quiet", dcnt, 0);
    do_op(4'h2, 4'b0011, -1, -1, "a2");

    for (int t = 0; t < 24; t++) begin
      do_op(int'($urandom_range(15)), (t < 12) ? 3 : int'($urandom_range(15)),
            -1, -1, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
